conv_feeder: RTL

CONV_FEEDER -- requirements
Module: conv_feeder

---
 rtl/conv_feeder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/conv_feeder.sv
// Streams a 3x3 kernel and then a row-major image from memory as 3-byte columns into a
// convolution engine, and tags each completed 3x3 window with its top-left coordinate.
module conv_feeder #(
   parameter int unsigned BIT_LEN  = 8,
   parameter int unsigned IMG_W    = 16,
   parameter int unsigned IMG_H    = 16,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned KER_BASE = 0,
   parameter int unsigned IMG_BASE = 16
) (
   input  logic               CLK100MHZ,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_hold,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_rd_en,
   output logic [ADDR_W-1:0]  o_addr,
   input  logic [BIT_LEN-1:0] i_rdata,
   output logic [BIT_LEN-1:0] o_dato0,
   output logic [BIT_LEN-1:0] o_dato1,
   output logic [BIT_LEN-1:0] o_dato2,
   output logic               o_valid,
   output logic               o_selecK_I,
   output logic               o_win_valid,
   output logic [7:0]         o_win_row,
   output logic [7:0]         o_win_col
);

   typedef enum logic [2:0] {IDLE, KREAD, KPUSH, IREAD, IPUSH, FLUSH, DONE} state_t;

   state_t             state_q, state_d;
   logic [1:0]         ri_q, ri_d;        // row within the column being read
   logic [8:0]         col_q, col_d;
   logic [7:0]         strip_q, strip_d;
   logic [BIT_LEN-1:0] b0_q, b1_q, b2_q;
   logic               rd_pend_q;
   logic [1:0]         rd_idx_q;
   logic               win_valid_q, win_valid_d;
   logic [7:0]         win_row_q, win_row_d;
   logic [7:0]         win_col_q, win_col_d;
   logic [ADDR_W-1:0]  addr_k, addr_i;
   logic [BIT_LEN-1:0] last_byte;

   assign addr_k = ADDR_W'(KER_BASE) + ADDR_W'(ri_q) * ADDR_W'(3) + ADDR_W'(col_q);
   assign addr_i = ADDR_W'(IMG_BASE) + (ADDR_W'(strip_q) + ADDR_W'(ri_q)) * ADDR_W'(IMG_W)
                   + ADDR_W'(col_q);

   // The bottom byte arrives during the push cycle itself unless a stall already latched it.
   assign last_byte = rd_pend_q ? i_rdata : b2_q;

   assign o_win_valid = win_valid_q;
   assign o_win_row   = win_row_q;
   assign o_win_col   = win_col_q;

   always_comb begin
      state_d     = state_q;
      ri_d        = ri_q;
      col_d       = col_q;
      strip_d     = strip_q;
      win_valid_d = 1'b0;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      o_busy      = (state_q != IDLE);
      o_done      = 1'b0;
      o_rd_en     = 1'b0;
      o_addr      = '0;
      o_valid     = 1'b0;
      o_selecK_I  = 1'b0;
      o_dato0     = '0;
      o_dato1     = '0;
      o_dato2     = '0;
      case (state_q)
         IDLE: begin
            if (i_start && !i_hold) begin
               state_d = KREAD;
               ri_d    = 2'd0;
               col_d   = 9'd0;
               strip_d = 8'd0;
            end
         end
         KREAD, IREAD: begin
            o_selecK_I = (state_q == IREAD);
            o_addr     = (state_q == IREAD) ? addr_i : addr_k;
            if (!i_hold) begin
               o_rd_en = 1'b1;
               if (ri_q == 2'd2) begin
                  ri_d    = 2'd0;
                  state_d = (state_q == IREAD) ? IPUSH : KPUSH;
               end else begin
                  ri_d = ri_q + 2'd1;
               end
            end
         end
         KPUSH: begin
            o_dato0 = b0_q;
            o_dato1 = b1_q;
            o_dato2 = last_byte;
            if (!i_hold) begin
               o_valid = 1'b1;
               if (col_q == 9'd2) begin
                  col_d   = 9'd0;
                  state_d = IREAD;
               end else begin
                  col_d   = col_q + 9'd1;
                  state_d = KREAD;
               end
            end
         end
         IPUSH: begin
            o_selecK_I = 1'b1;
            o_dato0    = b0_q;
            o_dato1    = b1_q;
            o_dato2    = last_byte;
            if (!i_hold) begin
               o_valid = 1'b1;
               if (col_q >= 9'd3) begin
                  win_valid_d = 1'b1;
                  win_row_d   = strip_q;
                  win_col_d   = 8'(col_q - 9'd3);
               end
               if (col_q == 9'(IMG_W - 1)) begin
                  state_d = FLUSH;
               end else begin
                  col_d   = col_q + 9'd1;
                  state_d = IREAD;
               end
            end
         end
         FLUSH: begin
            o_selecK_I = 1'b1;
            if (!i_hold) begin
               o_valid     = 1'b1;
               win_valid_d = 1'b1;
               win_row_d   = strip_q;
               win_col_d   = 8'(IMG_W - 3);
               col_d       = 9'd0;
               if (strip_q == 8'(IMG_H - 3)) begin
                  state_d = DONE;
               end else begin
                  strip_d = strip_q + 8'd1;
                  state_d = IREAD;
               end
            end
         end
         DONE: begin
            if (!i_hold) begin
               o_done  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (i_reset) begin
         state_q     <= IDLE;
         ri_q        <= 2'd0;
         col_q       <= 9'd0;
         strip_q     <= 8'd0;
         b0_q        <= '0;
         b1_q        <= '0;
         b2_q        <= '0;
         rd_pend_q   <= 1'b0;
         rd_idx_q    <= 2'd0;
         win_valid_q <= 1'b0;
         win_row_q   <= 8'd0;
         win_col_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         ri_q        <= ri_d;
         col_q       <= col_d;
         strip_q     <= strip_d;
         rd_pend_q   <= o_rd_en;
         rd_idx_q    <= ri_q;
         win_valid_q <= win_valid_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
         if (rd_pend_q) begin
            case (rd_idx_q)
               2'd0:    b0_q <= i_rdata;
               2'd1:    b1_q <= i_rdata;
               default: b2_q <= i_rdata;
            endcase
         end
      end
   end

endmodule
